// File: rtl/fb_scanout_reader_if.sv
// Pixel FIFO read port plus video output bundle between the scanout reader and its neighbours.
// master = scanout reader side, slave = FIFO / display side.
interface fb_scanout_reader_if #(
  parameter int DATA_W = 12
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_pop;
  logic [DATA_W-1:0] pix_rgb;
  logic              de;
  logic              hsync;
  logic              vsync;
  logic              frame_start;

  modport master (
    input  fifo_empty, fifo_rdata,
    output fifo_pop, pix_rgb, de, hsync, vsync, frame_start
  );

  modport slave (
    output fifo_empty, fifo_rdata,
    input  fifo_pop, pix_rgb, de, hsync, vsync, frame_start
  );
endinterface

// File: rtl/fb_scanout_reader.sv
// Pops one pixel per active-video clock from a show-ahead FIFO and drives registered VGA timing/RGB.
// Underruns blank the pixel without stalling the raster and are counted for the fetch side.
module fb_scanout_reader #(
  parameter int DATA_W   = 12,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                clk,
  input  logic                rst,
  fb_scanout_reader_if.master bus,
  input  logic                underrun_clr,
  output logic                underrun,
  output logic [15:0]         underrun_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic              run;
  logic              active;
  logic [DATA_W-1:0] pix_q;
  logic              de_q;
  logic              hs_q;
  logic              vs_q;
  logic              fs_q;

  assign run    = (state == RUN);
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  // Show-ahead FIFO: the head word is consumed in the same cycle it is registered.
  assign bus.fifo_pop    = run && active && !bus.fifo_empty && !rst;
  assign bus.pix_rgb     = pix_q;
  assign bus.de          = de_q;
  assign bus.hsync       = hs_q;
  assign bus.vsync       = vs_q;
  assign bus.frame_start = fs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      h_cnt        <= '0;
      v_cnt        <= '0;
      pix_q        <= '0;
      de_q         <= 1'b0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      fs_q         <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // First non-empty cycle only primes; the raster starts at (0,0) next clock.
          if (!bus.fifo_empty) state <= RUN;
        end
        RUN: begin
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
          end else begin
            h_cnt <= h_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      de_q  <= run && active;
      pix_q <= (run && active && !bus.fifo_empty) ? bus.fifo_rdata : '0;
      hs_q  <= !(run && (h_cnt >= HS_BEG) && (h_cnt <= HS_END));
      vs_q  <= !(run && (v_cnt >= VS_BEG) && (v_cnt <= VS_END));
      fs_q  <= run && (h_cnt == '0) && (v_cnt == '0);

      // A fresh underrun outranks a clear arriving in the same cycle.
      if (run && active && bus.fifo_empty) begin
        underrun <= 1'b1;
        if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fb_scanout_reader.sv
// Directed-plus-random bench for fb_scanout_reader with small raster (8x6 total, 4x3 active),
// checked against a frame-position model derived from a cycle count since priming.
module tb_fb_scanout_reader;
  localparam int DW      = 12;
  localparam int H_TOTAL = 8;
  localparam int V_TOTAL = 6;
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  logic        clk = 1'b0;
  logic        rst;
  logic        underrun_clr;
  logic        underrun;
  logic [15:0] underrun_cnt;

  fb_scanout_reader_if #(.DATA_W(DW)) vif ();

  fb_scanout_reader #(
    .DATA_W(DW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (vif),
    .underrun_clr (underrun_clr),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: running flag + cycles elapsed since the first raster clock.
  bit            m_run = 1'b0;
  int            t = 0;
  bit            e_under = 1'b0;
  int            e_cnt = 0;
  logic [DW-1:0] q[$];
  int            pops = 0;
  int            fs_seen = 0;
  int            vs_low = 0;
  int            cyc_no = 0;
  int            last_fs = -1;
  logic [DW-1:0] fs_pix = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    int h, v;
    bit act, emp, e_pop;
    logic [DW-1:0] rd, e_pix;
    logic e_de, e_hs, e_vs, e_fs;
    @(negedge clk);
    emp = (q.size() == 0);
    rd  = emp ? DW'($urandom) : q[0];
    vif.fifo_empty = emp;
    vif.fifo_rdata = rd;
    h     = t % H_TOTAL;
    v     = (t / H_TOTAL) % V_TOTAL;
    act   = m_run && (h < 4) && (v < 3);
    e_pop = act && !emp && !rst;
    #1;
    chk("fifo_pop", vif.fifo_pop, e_pop);
    if (e_pop) begin
      void'(q.pop_front());
      pops++;
    end
    if (rst) begin
      e_de = 0; e_pix = '0; e_hs = 1; e_vs = 1; e_fs = 0;
      e_under = 0; e_cnt = 0; m_run = 0; t = 0; last_fs = -1;
    end else begin
      e_de  = act;
      e_pix = (act && !emp) ? rd : '0;
      e_hs  = !(m_run && h >= 5 && h <= 6);
      e_vs  = !(m_run && v == 4);
      e_fs  = m_run && h == 0 && v == 0;
      if (act && emp) begin
        e_under = 1;
        if (e_cnt != 16'hFFFF) e_cnt++;
      end else if (underrun_clr) begin
        e_under = 0;
      end
      if (m_run) t++;
      else if (!emp) begin
        m_run = 1;
        t = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc_no++;
    chk("de", vif.de, e_de);
    chk("pix_rgb", vif.pix_rgb, e_pix);
    chk("hsync", vif.hsync, e_hs);
    chk("vsync", vif.vsync, e_vs);
    chk("frame_start", vif.frame_start, e_fs);
    chk("underrun", underrun, e_under);
    chk("underrun_cnt", underrun_cnt, e_cnt);
    if (!vif.vsync) vs_low++;
    if (vif.frame_start) begin
      fs_seen++;
      fs_pix = vif.pix_rgb;
      if (last_fs >= 0) chk("frame_period", cyc_no - last_fs, FRAME);
      last_fs = cyc_no;
    end
  endtask

  initial begin
    bit reached;
    rst = 1'b1;
    underrun_clr = 1'b0;
    vif.fifo_empty = 1'b1;
    vif.fifo_rdata = '0;

    repeat (2) cyc();
    rst = 1'b0;

    // Empty FIFO: reader must stay idle.
    repeat (20) cyc();
    chk("idle_pops", pops, 0);

    // Full first frame from 12 sequential pixels.
    for (int i = 1; i <= 12; i++) q.push_back(DW'(i));
    pops = 0; fs_seen = 0; vs_low = 0;
    cyc();
    repeat (FRAME) cyc();
    chk("frame0_pops", pops, 12);
    chk("frame0_fs_count", fs_seen, 1);
    chk("frame0_fs_pixel", fs_pix, 12'h001);
    chk("frame0_vsync_low", vs_low, 8);
    chk("frame0_underrun", underrun, 0);

    // Second frame: only 5 pixels available, 7 underruns.
    for (int i = 0; i < 5; i++) q.push_back(DW'($urandom));
    pops = 0;
    repeat (40) cyc();
    chk("frame1_pops", pops, 5);
    chk("frame1_underrun", underrun, 1);
    chk("frame1_underrun_cnt", underrun_cnt, 7);

    // Clear during blanking takes effect.
    underrun_clr = 1'b1;
    cyc();
    underrun_clr = 1'b0;
    chk("clr_blank", underrun, 0);
    repeat (7) cyc();

    // Clear coinciding with an underrun pixel is overridden.
    cyc();
    underrun_clr = 1'b1;
    cyc();
    underrun_clr = 1'b0;
    chk("clr_vs_underrun", underrun, 1);
    repeat (FRAME - 2) cyc();

    // Random fill and clear pulses over several frames.
    for (int i = 0; i < 4 * FRAME; i++) begin
      if ($urandom_range(0, 3) == 0 && q.size() < 8) q.push_back(DW'($urandom));
      underrun_clr = ($urandom_range(0, 9) == 0);
      cyc();
    end
    underrun_clr = 1'b0;

    // Reset mid-frame at (v=2, h=1).
    reached = 1'b0;
    for (int i = 0; i < 3 * FRAME && !reached; i++) begin
      if (m_run && (t % FRAME) == 17) reached = 1'b1;
      else begin
        if (q.size() < 4) q.push_back(DW'($urandom));
        cyc();
      end
    end
    chk("reach_rst_point", reached, 1);
    if (q.size() == 0) q.push_back(DW'($urandom));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_de", vif.de, 0);
    chk("rst_hsync", vif.hsync, 1);
    q.delete();
    pops = 0;
    repeat (3) cyc();
    chk("post_rst_idle_pops", pops, 0);

    // Re-prime and run a frame with random data.
    for (int i = 0; i < 12; i++) q.push_back(DW'($urandom));
    cyc();
    repeat (FRAME) cyc();
    chk("reprime_pops", pops, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
